// File: rtl/harris_pkg.sv
// Shared constants and the corner coordinate record used by the Harris pipeline stages.
package harris_pkg;

  localparam int unsigned RESP_W    = 16;
  localparam int unsigned IMG_W_DEF = 64;
  localparam int unsigned IMG_H_DEF = 64;
  localparam int unsigned CXW       = $clog2(IMG_W_DEF);
  localparam int unsigned CYW       = $clog2(IMG_H_DEF);

  // Sized for the default frame; smaller frames zero-extend into it.
  typedef struct packed {
    logic [CXW-1:0] x;
    logic [CYW-1:0] y;
  } corner_t;

endpackage

// File: rtl/corner_fifo.sv
// Synchronous FIFO of corner records; a push while full is accepted only if a pop frees a slot.
module corner_fifo import harris_pkg::*; #(
  parameter int unsigned DEPTH = 16
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  corner_t push_data,
  input  logic    pop,
  output corner_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  corner_t       mem [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head reads zero while empty so the outputs are defined straight after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/corner_nms.sv
// Thresholds the raster Harris response, applies 3x3 non-maximum suppression and queues
// surviving corner coordinates behind a valid/ready port.
module corner_nms import harris_pkg::*; #(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned RW         = RESP_W,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RW-1:0]            resp,
  input  logic                     resp_valid,
  input  logic [RW-1:0]            thresh,
  output logic [$clog2(IMG_W)-1:0] out_x,
  output logic [$clog2(IMG_H)-1:0] out_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;
  logic [RW-1:0] lb1 [IMG_W];
  logic [RW-1:0] lb2 [IMG_W];
  logic [RW-1:0] win_q [3][3];  // [row][col], row 0 is the oldest line
  logic          eval_q;
  logic [XW-1:0] ex_q;
  logic [YW-1:0] ey_q;
  logic          frame_done_q;
  logic          overflow_q;
  logic          col_last;
  logic          row_last;
  logic          is_corner;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  corner_t       push_data;
  corner_t       head;

  assign col_last = (col_q == XW'(IMG_W - 1));
  assign row_last = (row_q == YW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      eval_q       <= 1'b0;
      ex_q         <= '0;
      ey_q         <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
      end
    end else begin
      frame_done_q <= resp_valid && col_last && row_last;
      eval_q       <= resp_valid && (col_q >= XW'(2)) && (row_q >= YW'(2));
      ex_q         <= col_q - XW'(1);
      ey_q         <= row_q - YW'(1);
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      if (resp_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + YW'(1);
        end else begin
          col_q <= col_q + XW'(1);
        end
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb2[col_q];
        win_q[1][2] <= lb1[col_q];
        win_q[2][2] <= resp;
      end
    end
  end

  // Line buffers carry no reset; rows 0 and 1 refill them before any evaluation.
  always_ff @(posedge clk) begin
    if (resp_valid) begin
      lb1[col_q] <= resp;
      lb2[col_q] <= lb1[col_q];
    end
  end

  // Strict against earlier raster neighbours, non-strict against later ones: plateau goes
  // to its first pixel.
  always_comb begin
    is_corner = (win_q[1][1] > thresh)
             && (win_q[1][1] >  win_q[0][0]) && (win_q[1][1] >  win_q[0][1])
             && (win_q[1][1] >  win_q[0][2]) && (win_q[1][1] >  win_q[1][0])
             && (win_q[1][1] >= win_q[1][2]) && (win_q[1][1] >= win_q[2][0])
             && (win_q[1][1] >= win_q[2][1]) && (win_q[1][1] >= win_q[2][2]);
  end

  assign push      = eval_q && is_corner;
  assign pop       = out_valid && out_ready;
  assign push_data = corner_t'{x: CXW'(ex_q), y: CYW'(ey_q)};

  corner_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_x      = head.x[XW-1:0];
  assign out_y      = head.y[YW-1:0];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_corner_nms.sv
// Directed bench for corner_nms on an 8x8 frame with hand-computed corner lists.
module tb_corner_nms;

  logic        clk;
  logic        reset;
  logic [15:0] resp;
  logic        resp_valid;
  logic [15:0] thresh;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic        overflow;

  corner_nms #(
    .IMG_W      (8),
    .IMG_H      (8),
    .RW         (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .resp       (resp),
    .resp_valid (resp_valid),
    .thresh     (thresh),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          fd_cnt  = 0;
  int          qx[$];
  int          qy[$];
  logic [15:0] img [64];

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Record every popped entry and every frame_done cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      qx.push_back(int'(out_x));
      qy.push_back(int'(out_y));
    end
    if (frame_done) fd_cnt++;
  end

  task automatic fill(input int bg);
    for (int i = 0; i < 64; i++) img[i] = 16'(bg);
  endtask

  task automatic poke(input int x, input int y, input int v);
    img[y * 8 + x] = 16'(v);
  endtask

  task automatic clear_log();
    qx.delete();
    qy.delete();
    fd_cnt = 0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      resp       = img[i];
      resp_valid = 1'b1;
      @(posedge clk);
      #1;
      if (n == 64 && i == 62) check("frame_done_early", int'(frame_done), 0);
      if (n == 64 && i == 63) check("frame_done_pulse", int'(frame_done), 1);
    end
    resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    resp_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_one(input string tag, input int x, input int y);
    check({tag, "_count"}, qx.size(), 1);
    check({tag, "_x"}, (qx.size() > 0) ? qx[0] : -1, x);
    check({tag, "_y"}, (qy.size() > 0) ? qy[0] : -1, y);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    resp       = '0;
    resp_valid = 1'b0;
    thresh     = 16'd50;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    reset = 1'b0;

    // Single peak
    clear_log();
    fill(10);
    poke(3, 4, 200);
    send(64);
    idle(10);
    expect_one("single", 3, 4);
    check("single_fd_cnt", fd_cnt, 1);
    check("single_overflow", int'(overflow), 0);

    // Threshold boundary: strictly greater than thresh
    clear_log();
    fill(10);
    poke(3, 4, 50);
    send(64);
    idle(10);
    check("thr_equal_count", qx.size(), 0);
    clear_log();
    thresh = 16'd49;
    send(64);
    idle(10);
    expect_one("thr_above", 3, 4);
    thresh = 16'd50;

    // Plateau
    clear_log();
    fill(10);
    poke(3, 4, 200);
    poke(4, 4, 200);
    poke(3, 5, 200);
    send(64);
    idle(10);
    expect_one("plateau", 3, 4);

    // Border peaks
    clear_log();
    fill(10);
    poke(0, 3, 200);
    poke(7, 3, 200);
    poke(3, 7, 200);
    send(64);
    idle(10);
    check("border_count", qx.size(), 0);
    check("border_overflow", int'(overflow), 0);

    // Backpressure: 9 isolated peaks per frame, two frames -> 18 corners into 16 slots
    clear_log();
    out_ready = 1'b0;
    fill(10);
    for (int y = 1; y < 6; y += 2) begin
      for (int x = 1; x < 6; x += 2) poke(x, y, 100 + x + 8 * y);
    end
    send(64);
    send(64);
    idle(10);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_overflow", int'(overflow), 1);
    check("bp_no_pop", qx.size(), 0);
    check("bp_head_x", int'(out_x), 1);
    check("bp_head_y", int'(out_y), 1);
    idle(3);
    check("bp_stable_x", int'(out_x), 1);
    check("bp_stable_y", int'(out_y), 1);
    out_ready = 1'b1;
    idle(25);
    check("bp_drain_count", qx.size(), 16);
    for (int k = 0; k < 16; k++) begin
      int f;
      f = (k < 9) ? k : k - 9;
      check($sformatf("bp_x%0d", k), (qx.size() > k) ? qx[k] : -1, 1 + 2 * (f % 3));
      check($sformatf("bp_y%0d", k), (qy.size() > k) ? qy[k] : -1, 1 + 2 * (f / 3));
    end
    check("bp_drained_valid", int'(out_valid), 0);

    // Reset mid-frame
    clear_log();
    fill(10);
    poke(5, 5, 200);
    send(20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    @(posedge clk);
    #1;
    check("midrst_overflow", int'(overflow), 0);
    reset = 1'b0;
    clear_log();
    fill(10);
    poke(3, 4, 200);
    send(64);
    idle(10);
    expect_one("midrst", 3, 4);
    check("midrst_fd_cnt", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
